uart_rx_fifo: RTL and testbench

// Receive buffer directly downstream of the UART receiver core. Captures each

---
 rtl/uart_rx_fifo.sv | 87 ++++++++
 tb/tb_uart_rx_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with overrun detection and level threshold
module uart_rx_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int RX_THRESHOLD = 8
) (
    input  logic                         uart_clk,
    input  logic                         rst_n,
    input  logic                         sample_tick,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         flush,
    input  logic                         overrun_clr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         rx_thresh,
    output logic                         overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(RX_THRESHOLD);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overrun_q, overrun_d;
    logic                  push_req, pop, push_ok, drop;

    always_comb begin
        push_req  = sample_tick & in_valid;
        pop       = (count_q != '0) & out_ready;
        // A full FIFO still takes a byte when the head leaves in the same cycle.
        push_ok   = push_req & ((count_q != DEPTH_C) | pop);
        drop      = push_req & (count_q == DEPTH_C) & ~pop & ~flush;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_ok & ~pop)      count_d = count_q + CW'(1);
            else if (pop & ~push_ok) count_d = count_q - CW'(1);
        end
        overrun_d = drop | (overrun_q & ~overrun_clr);
    end

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge uart_clk) begin
        if (push_ok & ~flush) mem_q[wr_ptr_q] <= in_data;
    end

    assign in_ready  = 1'b1;
    assign count     = count_q;
    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign out_valid = ~empty;
    assign rx_thresh = (count_q >= THRESH_C);
    assign overrun   = overrun_q;
    // Storage is not reset, so the idle head reads as zero rather than stale data.
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue model
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       uart_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_tick = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       flush = 1'b0;
    logic       overrun_clr = 1'b0;
    logic [4:0] count;
    logic       full, empty, rx_thresh, overrun;

    int checks = 0;
    int failures = 0;
    int maxcnt = 0;

    logic [7:0] mq[$];
    logic [7:0] dut_log[$];
    logic       m_ovr = 1'b0;
    logic       m_pop, m_preq, m_drop;

    uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .RX_THRESHOLD(8)) dut (
        .uart_clk(uart_clk), .rst_n(rst_n), .sample_tick(sample_tick),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .flush(flush), .overrun_clr(overrun_clr), .count(count),
        .full(full), .empty(empty), .rx_thresh(rx_thresh), .overrun(overrun)
    );

    always #5 uart_clk = ~uart_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: a byte queue plus a sticky flag, updated from the pin-level rules.
    always @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ovr = 1'b0;
        end else begin
            m_pop  = (mq.size() != 0) && out_ready;
            m_preq = sample_tick && in_valid;
            m_drop = 1'b0;
            if (flush) mq.delete();
            else begin
                if (m_pop) void'(mq.pop_front());
                if (m_preq) begin
                    if (mq.size() < DEPTH) mq.push_back(in_data);
                    else m_drop = 1'b1;
                end
            end
            if (m_drop) m_ovr = 1'b1;
            else if (overrun_clr) m_ovr = 1'b0;
        end
    end

    always @(negedge uart_clk) begin
        if (rst_n) begin
            chk("count", 32'(count), 32'(mq.size()));
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            chk("full", 32'(full), 32'(mq.size() == DEPTH));
            chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("rx_thresh", 32'(rx_thresh), 32'(mq.size() >= 8));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("in_ready", 32'(in_ready), 32'd1);
            if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
            if (out_valid && out_ready) dut_log.push_back(out_data);
            if (int'(count) > maxcnt) maxcnt = int'(count);
        end
    end

    task automatic cyc();
        @(posedge uart_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        sample_tick = 1'b1;
        in_valid    = 1'b1;
        in_data     = b;
        cyc();
        sample_tick = 1'b0;
        in_valid    = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 40 && out_valid; k++) cyc();
        out_ready = 1'b0;
        chk("drain_done", 32'(out_valid), 32'd0);
    endtask

    initial begin
        repeat (3) cyc();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_thresh", 32'(rx_thresh), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 5; i++) push(8'(8'h11 + i));
        chk("t1_count5", 32'(count), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("t1_async_count", 32'(count), 32'd0);
        chk("t1_async_empty", 32'(empty), 32'd1);
        chk("t1_async_valid", 32'(out_valid), 32'd0);
        chk("t1_async_overrun", 32'(overrun), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        push(8'hA5);
        chk("t1_a5_valid", 32'(out_valid), 32'd1);
        chk("t1_a5_data", 32'(out_data), 32'hA5);
        drain();

        dut_log.delete();
        maxcnt = 0;
        for (int i = 0; i < 32; i++) begin
            sample_tick = 1'b1;
            in_valid    = 1'b1;
            in_data     = 8'(i);
            out_ready   = (i % 3 != 0);
            cyc();
        end
        sample_tick = 1'b0;
        in_valid    = 1'b0;
        drain();
        chk("t2_log_size", 32'(dut_log.size()), 32'd32);
        for (int i = 0; i < 32 && i < dut_log.size(); i++)
            chk("t2_order", 32'(dut_log[i]), 32'(i));
        chk("t2_max_le_depth", 32'(maxcnt <= DEPTH), 32'd1);

        in_valid = 1'b1;
        in_data  = 8'h5A;
        for (int k = 0; k < 40; k++) begin
            sample_tick = (k == 20);
            cyc();
        end
        sample_tick = 1'b0;
        in_valid    = 1'b0;
        chk("t3_count1", 32'(count), 32'd1);
        chk("t3_data", 32'(out_data), 32'h5A);
        drain();

        for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
        chk("t4_full", 32'(full), 32'd1);
        chk("t4_count16", 32'(count), 32'd16);
        push(8'h77);
        chk("t4_overrun", 32'(overrun), 32'd1);
        chk("t4_count_hold", 32'(count), 32'd16);
        chk("t4_head", 32'(out_data), 32'h40);
        overrun_clr = 1'b1;
        cyc();
        overrun_clr = 1'b0;
        chk("t4_clr", 32'(overrun), 32'd0);
        overrun_clr = 1'b1;
        push(8'h78);
        overrun_clr = 1'b0;
        chk("t4_set_wins", 32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        cyc();
        overrun_clr = 1'b0;
        chk("t4_clr2", 32'(overrun), 32'd0);

        dut_log.delete();
        out_ready = 1'b1;
        push(8'h3C);
        out_ready = 1'b0;
        chk("t5_count16", 32'(count), 32'd16);
        chk("t5_no_overrun", 32'(overrun), 32'd0);
        drain();
        chk("t5_log_size", 32'(dut_log.size()), 32'd17);
        if (dut_log.size() > 0) begin
            chk("t5_first", 32'(dut_log[0]), 32'h40);
            chk("t5_last", 32'(dut_log[dut_log.size()-1]), 32'h3C);
        end

        for (int i = 0; i < 7; i++) push(8'(8'h60 + i));
        chk("t6_count7", 32'(count), 32'd7);
        chk("t6_thresh_lo", 32'(rx_thresh), 32'd0);
        push(8'h67);
        chk("t6_thresh_hi", 32'(rx_thresh), 32'd1);
        flush     = 1'b1;
        out_ready = 1'b1;
        push(8'h99);
        flush     = 1'b0;
        out_ready = 1'b0;
        chk("t6_flush_count", 32'(count), 32'd0);
        chk("t6_flush_empty", 32'(empty), 32'd1);
        chk("t6_flush_thresh", 32'(rx_thresh), 32'd0);
        chk("t6_flush_ovr", 32'(overrun), 32'd0);
        for (int i = 0; i < 17; i++) push(8'(8'h80 + i));
        chk("t6_ovr_set", 32'(overrun), 32'd1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("t6_flush2_count", 32'(count), 32'd0);
        chk("t6_flush2_ovr", 32'(overrun), 32'd1);
        push(8'hC3);
        chk("t6_after_flush", 32'(out_data), 32'hC3);
        drain();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
